nanci_mesh: RTL and testbench
=============================

# nanci_mesh

Self-contained sorting mesh of N processing elements (PEs) arranged as an R×R grid (R = sqrt(N)). Each PE holds one {address, data} record. The mesh runs a shear sort keyed on address, so PE k ends up holding the record whose address is k. It is the top-level array of the Nanci fabric. After reset it sorts a built-in initial pattern with no external stimulus, then exposes per-PE results.

## Interface
- N, 4: number of PEs; must be a perfect square, R = sqrt(N).
- SORT_CYCLES, 4: number of shear iterations (row phase + column phase pairs); must be ≥ ceil(log2 R)+1.
- DATA_WIDTH, 32: record data width.
- ADDR_WIDTH, 2: record address width, = log2 N.
- WIDTH (derived), ADDR_WIDTH+DATA_WIDTH.
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- done  output  1  high once sorting completes.
- result  output  N*(WIDTH+1)  concatenated per-PE results; slice k is PE k's nanci_result.

## Operation
- PE k sits at row k/R, column k%R (row-major).
- Each PE is instantiated as GEN[k].GENIF.PE. It contains app_init with register nanci_result[WIDTH:0] = {busy, addr[ADDR_WIDTH-1:0], data[DATA_WIDTH-1:0]}. Testbenches probe this path hierarchically.
- Initial pattern, loaded in reset: PE i holds addr = N-1-i, data = i, busy = 1.
- Compare-exchange between neighbours uses addr only, unsigned. On equal keys, no swap. Data always travels with its addr.
- Phase = R odd-even transposition steps along a line of R PEs:
  - Even steps compare pairs (0,1),(2,3)….
  - Odd steps compare pairs (1,2),(3,4)….
  - The step type alternates, starting with even.
- Row phase (snake): even rows sort ascending left→right; odd rows sort descending.
- Column phase: all columns sort ascending top→bottom.
- Schedule: SORT_CYCLES × (row phase, column phase), then one final row phase with all rows ascending. This converts snake order to row-major order.
- Completion:
  - Every PE's busy bit clears.
  - done rises.
  - The mesh is idle and holds results until reset.
- Final state: PE k holds {0, k, N-1-k}.
- A central controller holds a phase counter, step counter, and phase type, and broadcasts them to all PEs. States: SORT_ROW, SORT_COL, FINAL_ROW, DONE.

## Timing
- Reset (rst low), asynchronous:
  - counters cleared; state SORT_ROW, step 0;
  - done = 0;
  - every nanci_result = {1, N-1-k, k}.
- First compare-exchange happens on the first rising clk edge with rst high. One step per cycle; both PEs of a pair update on the same edge.
- Total sort latency = (2·SORT_CYCLES+1)·R cycles. This is 18 cycles for the defaults.
- On the edge that completes the final step: the busy bits clear and done goes to 1 on that same edge.
- Reset asserted mid-sort: the pattern reloads immediately and the sort restarts from step 0 after release.
- No input handshake; result is valid only while done = 1.

## Test plan
- Reset release with defaults (N=4), wait 100 cycles → every nanci_result equals {0, k, 3-k}: PE0 {0,0,3}, PE1 {0,1,2}, PE2 {0,2,1}, PE3 {0,3,0}; done = 1.
- During reset → done = 0; PE0 = {1,3,0} and PE3 = {1,0,3}. The result bus mirrors the per-PE registers.
- Count cycles from reset release → done rises exactly 18 cycles later. Results are unchanged for 50 further cycles.
- Assert rst low for 1 cycle at cycle 7 of the sort → immediate reload of the initial pattern. Completion occurs 18 cycles after the second release with the correct final values.
- N=16, ADDR_WIDTH=4, SORT_CYCLES=3 → after 28 cycles PE k holds {0, k, 15-k} for all 16 PEs.
- Snapshot after the first row phase (N=4, after cycle 2) → row 0 ascending, row 1 descending by addr. PE0 addr 2, PE1 addr 3, PE2 addr 1, PE3 addr 0.

Source files
------------

// File: rtl/nanci_mesh.sv
// nanci_mesh: R x R shear-sort mesh keyed on record address.
// A central controller broadcasts phase/step; each PE does compare-exchange.
module nanci_app_init #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 32,
   parameter int WIDTH      = ADDR_WIDTH + DATA_WIDTH,
   parameter logic [WIDTH:0] INIT = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_last,
   input  logic             i_ok,
   input  logic             i_is_lo,
   input  logic             i_asc,
   input  logic [WIDTH-1:0] i_partner,
   output logic [WIDTH:0]   o_result
);
   logic [WIDTH:0]        nanci_result;
   logic [ADDR_WIDTH-1:0] w_own_a;
   logic [ADDR_WIDTH-1:0] w_par_a;
   logic [ADDR_WIDTH-1:0] w_lo_a;
   logic [ADDR_WIDTH-1:0] w_hi_a;
   logic                  w_swap;

   assign w_own_a = nanci_result[WIDTH-1 -: ADDR_WIDTH];
   assign w_par_a = i_partner[WIDTH-1 -: ADDR_WIDTH];
   assign w_lo_a  = i_is_lo ? w_own_a : w_par_a;
   assign w_hi_a  = i_is_lo ? w_par_a : w_own_a;
   // Both PEs of a pair see the same lo/hi keys, so they agree on the swap.
   assign w_swap  = i_en & i_ok &
                    (i_asc ? (w_lo_a > w_hi_a) : (w_lo_a < w_hi_a));
   assign o_result = nanci_result;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nanci_result <= INIT;
      end else if (i_en) begin
         if (w_swap) nanci_result[WIDTH-1:0] <= i_partner;
         if (i_last) nanci_result[WIDTH] <= 1'b0;
      end
   end
endmodule

module nanci_pe #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 32,
   parameter int WIDTH      = ADDR_WIDTH + DATA_WIDTH,
   parameter logic [WIDTH:0] INIT = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_last,
   input  logic             i_ok,
   input  logic             i_is_lo,
   input  logic             i_asc,
   input  logic [WIDTH-1:0] i_partner,
   output logic [WIDTH:0]   o_result
);
   nanci_app_init #(
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
      .WIDTH(WIDTH), .INIT(INIT)
   ) app_init (
      .clk(clk), .rst(rst), .i_en(i_en), .i_last(i_last),
      .i_ok(i_ok), .i_is_lo(i_is_lo), .i_asc(i_asc),
      .i_partner(i_partner), .o_result(o_result)
   );
endmodule

module nanci_mesh #(
   parameter int N           = 4,
   parameter int SORT_CYCLES = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 2
) (
   input  logic                                      clk,
   input  logic                                      rst,
   output logic                                      done,
   output logic [N*(ADDR_WIDTH+DATA_WIDTH+1)-1:0]    result
);
   localparam int WIDTH = ADDR_WIDTH + DATA_WIDTH;

   function automatic int isqrt(input int n);
      int r;
      r = 0;
      for (int i = 1; i <= n; i++) if (i * i <= n) r = i;
      return r;
   endfunction

   localparam int R  = isqrt(N);
   localparam int SW = (R > 1) ? $clog2(R) : 1;
   localparam int PW = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;
   localparam logic [SW-1:0] STEP_LAST = SW'(R - 1);
   localparam logic [PW-1:0] PH_LAST   = PW'(SORT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_ROW, S_COL, S_FIN, S_DONE
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [SW-1:0] r_step, w_step_nxt;
   logic [PW-1:0] r_phase, w_phase_nxt;
   logic          w_step_last;
   logic          w_en;
   logic          w_col;
   logic          w_snake;
   logic          w_last;
   logic          w_par;
   logic [WIDTH:0] w_pe [N];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_ROW;
         r_step  <= '0;
         r_phase <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_step  <= w_step_nxt;
         r_phase <= w_phase_nxt;
      end
   end

   assign w_step_last = (r_step == STEP_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      w_phase_nxt = r_phase;
      unique case (r_state)
         S_ROW: if (w_step_last) w_state_nxt = S_COL;
         S_COL: if (w_step_last) begin
            if (r_phase == PH_LAST) begin
               w_state_nxt = S_FIN;
            end else begin
               w_state_nxt = S_ROW;
               w_phase_nxt = r_phase + 1'b1;
            end
         end
         S_FIN: if (w_step_last) w_state_nxt = S_DONE;
         default: ;
      endcase
      if (r_state != S_DONE)
         w_step_nxt = w_step_last ? '0 : r_step + 1'b1;
   end

   assign w_en    = (r_state != S_DONE);
   assign w_col   = (r_state == S_COL);
   assign w_snake = (r_state == S_ROW);
   assign w_last  = (r_state == S_FIN) && w_step_last;
   assign w_par   = r_step[0];
   assign done    = (r_state == S_DONE);

   for (genvar k = 0; k < N; k++) begin : GEN
      localparam int ROW = k / R;
      localparam int COL = k % R;
      localparam int KR  = (COL < R - 1) ? k + 1 : k;
      localparam int KL  = (COL > 0) ? k - 1 : k;
      localparam int KD  = (ROW < R - 1) ? k + R : k;
      localparam int KU  = (ROW > 0) ? k - R : k;
      localparam logic HAS_R = (COL < R - 1);
      localparam logic HAS_L = (COL > 0);
      localparam logic HAS_D = (ROW < R - 1);
      localparam logic HAS_U = (ROW > 0);
      localparam logic ROW_P = 1'(ROW % 2);
      localparam logic COL_P = 1'(COL % 2);
      localparam logic [WIDTH:0] INIT =
         {1'b1, ADDR_WIDTH'(N - 1 - k), DATA_WIDTH'(k)};

      if (k < N) begin : GENIF
         logic             w_lo;
         logic             w_ok;
         logic             w_asc;
         logic [WIDTH-1:0] w_partner;

         always_comb begin
            w_lo      = w_col ? (ROW_P == w_par) : (COL_P == w_par);
            w_ok      = 1'b0;
            w_partner = '0;
            if (w_col) begin
               w_ok      = w_lo ? HAS_D : HAS_U;
               w_partner = w_lo ? w_pe[KD][WIDTH-1:0] : w_pe[KU][WIDTH-1:0];
            end else begin
               w_ok      = w_lo ? HAS_R : HAS_L;
               w_partner = w_lo ? w_pe[KR][WIDTH-1:0] : w_pe[KL][WIDTH-1:0];
            end
            // Odd rows run descending only during snake row phases.
            w_asc = !(w_snake && ROW_P);
         end

         nanci_pe #(
            .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
            .WIDTH(WIDTH), .INIT(INIT)
         ) PE (
            .clk(clk), .rst(rst), .i_en(w_en), .i_last(w_last),
            .i_ok(w_ok), .i_is_lo(w_lo), .i_asc(w_asc),
            .i_partner(w_partner), .o_result(w_pe[k])
         );
      end

      assign result[k*(WIDTH+1) +: WIDTH+1] = w_pe[k];
   end
endmodule

// File: tb/tb_nanci_mesh.sv
// tb_nanci_mesh: randomized reset/abort runs on N=4 and N=16 meshes,
// scoreboarded against a record-level sort model.
module tb_nanci_mesh;
   localparam int BW = 592;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic           done4, done16;
   logic [139:0]   res4;
   logic [591:0]   res16;

   nanci_mesh #(
      .N(4), .SORT_CYCLES(4), .DATA_WIDTH(32), .ADDR_WIDTH(2)
   ) u4 (
      .clk(clk), .rst(rst), .done(done4), .result(res4)
   );

   nanci_mesh #(
      .N(16), .SORT_CYCLES(3), .DATA_WIDTH(32), .ADDR_WIDTH(4)
   ) u16 (
      .clk(clk), .rst(rst), .done(done16), .result(res16)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      int            lat;
      logic [BW-1:0] res;
   } exp_t;

   typedef struct {
      bit busy;
      int addr;
      int data;
   } rec_t;

   exp_t q4[$];
   exp_t q16[$];
   rec_t m[16];

   function automatic void chk(string name, logic [BW-1:0] act,
                               logic [BW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endfunction

   function automatic void chk_int(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endfunction

   function automatic void load_init(int n);
      for (int i = 0; i < n; i++) m[i] = '{1'b1, n - 1 - i, i};
   endfunction

   // Sorted outcome: slot k takes the record whose address is k.
   function automatic void sort_final(int n);
      rec_t t[16];
      for (int k = 0; k < n; k++)
         for (int j = 0; j < n; j++)
            if (m[j].addr == k) t[k] = m[j];
      for (int k = 0; k < n; k++) begin
         m[k] = t[k];
         m[k].busy = 1'b0;
      end
   endfunction

   // One snake row phase fully sorts each row.
   function automatic void row_sort(int n, int r);
      rec_t tmp;
      for (int row = 0; row < r; row++)
         for (int a = 0; a < r; a++)
            for (int b = 0; b < r - 1; b++) begin
               int i0, i1;
               bit sw;
               i0 = row * r + b;
               i1 = i0 + 1;
               sw = (row % 2 == 0) ? (m[i0].addr > m[i1].addr)
                                   : (m[i0].addr < m[i1].addr);
               if (sw) begin
                  tmp   = m[i0];
                  m[i0] = m[i1];
                  m[i1] = tmp;
               end
            end
   endfunction

   function automatic logic [BW-1:0] pack(int n, int aw);
      logic [BW-1:0] v;
      logic [BW-1:0] e;
      v = '0;
      for (int i = 0; i < n; i++) begin
         e = '0;
         e[aw+32] = m[i].busy;
         e = e | (BW'(m[i].addr) << 32) | BW'(m[i].data);
         v = v | (e << (i * (aw + 33)));
      end
      return v;
   endfunction

   function automatic logic [BW-1:0] model_init(int n, int aw);
      load_init(n);
      return pack(n, aw);
   endfunction

   function automatic logic [BW-1:0] model_final(int n, int aw);
      load_init(n);
      sort_final(n);
      return pack(n, aw);
   endfunction

   function automatic logic [BW-1:0] model_row(int n, int r, int aw);
      load_init(n);
      row_sort(n, r);
      return pack(n, aw);
   endfunction

   int cnt;
   always @(posedge clk or negedge rst) begin
      if (!rst) cnt <= 0;
      else      cnt <= cnt + 1;
   end

   bit   seen4  = 1'b0;
   bit   seen16 = 1'b0;
   exp_t e4, e16;

   always @(negedge clk) begin
      if (!rst) begin
         seen4 = 1'b0;
      end else if (done4 && !seen4) begin
         seen4 = 1'b1;
         if (q4.size() == 0) begin
            total++;
            bad++;
            $display("FAIL done4_early cnt=%0d exp=no_completion", cnt);
         end else begin
            e4 = q4.pop_front();
            chk_int("lat4", cnt, e4.lat);
            chk("res4", BW'(res4), e4.res);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         seen16 = 1'b0;
      end else if (done16 && !seen16) begin
         seen16 = 1'b1;
         if (q16.size() == 0) begin
            total++;
            bad++;
            $display("FAIL done16_early cnt=%0d exp=no_completion", cnt);
         end else begin
            e16 = q16.pop_front();
            chk_int("lat16", cnt, e16.lat);
            chk("res16", res16, e16.res);
         end
      end
   end

   initial begin
      exp_t pe;
      int   abort_at;
      int   hold;
      bit   got;
      repeat (2) @(negedge clk);
      for (int it = 0; it < 8; it++) begin
         rst = 1'b0;
         #1;
         chk_int("rst_done4", int'(done4), 0);
         chk_int("rst_done16", int'(done16), 0);
         chk("rst_res4", BW'(res4), model_init(4, 2));
         chk("rst_res16", res16, model_init(16, 4));
         chk_int("rst_pe0", int'(u4.GEN[0].GENIF.PE.app_init.nanci_result),
                 int'(35'h4_0000_0000 | (35'd3 << 32)));
         repeat ($urandom_range(1, 3)) @(negedge clk);
         rst = 1'b1;

         if (it == 1)      abort_at = 7;
         else if (it == 2) abort_at = 0;
         else if ($urandom_range(0, 2) == 0)
            abort_at = $urandom_range(1, 17);
         else
            abort_at = 0;

         if (abort_at == 0) begin
            pe.lat = 18;
            pe.res = model_final(4, 2);
            q4.push_back(pe);
            pe.lat = 28;
            pe.res = model_final(16, 4);
            q16.push_back(pe);
         end

         got = 1'b0;
         for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 2) begin
               chk("snap4", BW'(res4), model_row(4, 2, 2));
               chk_int("snap_done4", int'(done4), 0);
            end
            if (c == 4) chk("snap16", res16, model_row(16, 4, 4));
            if (abort_at != 0 && c == abort_at) break;
            if (done4 && done16) begin
               got = 1'b1;
               break;
            end
         end

         if (abort_at == 0) begin
            total++;
            if (!got) begin
               bad++;
               $display("FAIL done_timeout act=no_done exp=done_by_200");
            end
            hold = $urandom_range(5, 50);
            repeat (hold) @(negedge clk);
            chk("hold_res4", BW'(res4), model_final(4, 2));
            chk("hold_res16", res16, model_final(16, 4));
            chk_int("hold_done4", int'(done4), 1);
            chk_int("hold_done16", int'(done16), 1);
         end
      end
      chk_int("q4_drained", q4.size(), 0);
      chk_int("q16_drained", q16.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
